// File: rtl/ssrecv.sv
// ssrecv: seven-segment scan receiver. Debounces a multiplexed display bus, recovers
// per-digit nibble/blank/error and reports each digit change on a valid/ready port.
// Optional feature macro: DP_CAPTURE_EN (capture the decimal point, seg_in[7]).
module ssrecv #(
   parameter int NUM_DIGITS    = 4,
   parameter int STABLE_CYCLES = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [7:0]                seg_in,
   input  logic [NUM_DIGITS-1:0]     dig_sel,
   output logic [4*NUM_DIGITS-1:0]   digits_out,
   output logic [NUM_DIGITS-1:0]     blank_out,
   output logic [NUM_DIGITS-1:0]     err_out,
   output logic [NUM_DIGITS-1:0]     dp_out,
   output logic                      upd_valid,
   output logic [2:0]                upd_idx,
   output logic [3:0]                upd_nibble,
   input  logic                      upd_ready
);
   localparam logic [0:0] ST_IDLE    = 1'b0;
   localparam logic [0:0] ST_PRESENT = 1'b1;
   localparam logic [3:0] SC         = 4'(STABLE_CYCLES);

`ifdef DP_CAPTURE_EN
   localparam logic [7:0] SEG_MASK = 8'hFF;
`else
   localparam logic [7:0] SEG_MASK = 8'h7F;
`endif

   // {hit, nibble}; hit=0 for blank or undecodable patterns
   function automatic logic [4:0] decode(input logic [6:0] s);
      case (s)
         7'h3F: decode = {1'b1, 4'h0};
         7'h06: decode = {1'b1, 4'h1};
         7'h5B: decode = {1'b1, 4'h2};
         7'h4F: decode = {1'b1, 4'h3};
         7'h66: decode = {1'b1, 4'h4};
         7'h6D: decode = {1'b1, 4'h5};
         7'h7D: decode = {1'b1, 4'h6};
         7'h07: decode = {1'b1, 4'h7};
         7'h7F: decode = {1'b1, 4'h8};
         7'h67: decode = {1'b1, 4'h9};
         7'h77: decode = {1'b1, 4'hA};
         7'h7C: decode = {1'b1, 4'hB};
         7'h39: decode = {1'b1, 4'hC};
         7'h5E: decode = {1'b1, 4'hD};
         7'h79: decode = {1'b1, 4'hE};
         7'h71: decode = {1'b1, 4'hF};
         default: decode = 5'h00;
      endcase
   endfunction

   logic [NUM_DIGITS-1:0]       samp_sel_q, samp_sel_d;
   logic [7:0]                  samp_seg_q, samp_seg_d;
   logic [3:0]                  cnt_q, cnt_d;
   logic [NUM_DIGITS-1:0][3:0]  nib_q, nib_d;
   logic [NUM_DIGITS-1:0]       blank_q, blank_d, err_q, err_d, dp_q, dp_d, dirty_q, dirty_d;
   logic [0:0]                  state_q, state_d;
   logic [2:0]                  idx_q, idx_d;
   logic [3:0]                  unib_q, unib_d;

   logic [7:0]                  seg_m;
   logic                        match, onehot, commit, load, new_blank, new_err, new_dp;
   logic [4:0]                  dec;
   logic [3:0]                  new_nib, lo_nib;
   logic [2:0]                  lo_idx;
   logic [NUM_DIGITS-1:0]       lo_oh;

   always_comb begin
      seg_m      = seg_in & SEG_MASK;
      match      = (dig_sel == samp_sel_q) && (seg_m == samp_seg_q);
      onehot     = (dig_sel != '0) && ((dig_sel & (dig_sel - NUM_DIGITS'(1))) == '0);
      commit     = match && onehot && (cnt_q == SC - 4'd1);
      samp_sel_d = dig_sel;
      samp_seg_d = seg_m;
      cnt_d      = '0;
      if (match && onehot)
         cnt_d = (cnt_q >= SC) ? SC : cnt_q + 4'd1;

      dec       = decode(seg_in[6:0]);
      new_blank = (seg_in[6:0] == 7'h00);
      new_err   = !dec[4] && !new_blank;
      new_dp    = seg_m[7];

      // lowest-index dirty digit wins the event port
      lo_idx = '0;
      lo_nib = '0;
      lo_oh  = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         if (dirty_q[i]) begin
            lo_idx = 3'(i);
            lo_nib = nib_q[i];
            lo_oh  = '0;
            lo_oh[i] = 1'b1;
         end
      end

      state_d = state_q;
      idx_d   = idx_q;
      unib_d  = unib_q;
      dirty_d = dirty_q;
      load    = (dirty_q != '0) && ((state_q == ST_IDLE) || upd_ready);
      if (load) begin
         state_d = ST_PRESENT;
         idx_d   = lo_idx;
         unib_d  = lo_nib;
         dirty_d = dirty_q & ~lo_oh;
      end else if ((state_q == ST_PRESENT) && upd_ready) begin
         state_d = ST_IDLE;
      end

      // commit applied after the event clear so a same-edge set wins
      nib_d   = nib_q;
      blank_d = blank_q;
      err_d   = err_q;
      dp_d    = dp_q;
      new_nib = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (commit && dig_sel[i]) begin
            new_nib = dec[4] ? dec[3:0] : (new_blank ? 4'h0 : nib_q[i]);
            if ({new_nib, new_blank, new_err, new_dp} != {nib_q[i], blank_q[i], err_q[i], dp_q[i]})
               dirty_d[i] = 1'b1;
            nib_d[i]   = new_nib;
            blank_d[i] = new_blank;
            err_d[i]   = new_err;
            dp_d[i]    = new_dp;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         samp_sel_q <= '0;
         samp_seg_q <= '0;
         cnt_q      <= '0;
         nib_q      <= '0;
         blank_q    <= '0;
         err_q      <= '0;
         dp_q       <= '0;
         dirty_q    <= '0;
         state_q    <= ST_IDLE;
         idx_q      <= '0;
         unib_q     <= '0;
      end else begin
         samp_sel_q <= samp_sel_d;
         samp_seg_q <= samp_seg_d;
         cnt_q      <= cnt_d;
         nib_q      <= nib_d;
         blank_q    <= blank_d;
         err_q      <= err_d;
         dp_q       <= dp_d;
         dirty_q    <= dirty_d;
         state_q    <= state_d;
         idx_q      <= idx_d;
         unib_q     <= unib_d;
      end
   end

   // dp_q stays 0 without DP_CAPTURE_EN because seg_m[7] is masked off
   assign digits_out = nib_q;
   assign blank_out  = blank_q;
   assign err_out    = err_q;
   assign dp_out     = dp_q;
   assign upd_valid  = (state_q == ST_PRESENT);
   assign upd_idx    = idx_q;
   assign upd_nibble = unib_q;
endmodule
